// File: rtl/rg_rd_arb.sv
// rg_rd_arb: round-robin arbiter and burst read sequencer sharing the resource-grid RAM read port.
// Optional grant-time range check with sticky err output: define RG_RD_ARB_RANGE_CHK_EN.
module rg_rd_arb #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned SC_PER_SYM = 240,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned MEM_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [1:0]        req0_sym,
  input  logic [LEN_W-1:0]  req0_start,
  input  logic [LEN_W-1:0]  req0_len,
  input  logic              req1,
  input  logic [1:0]        req1_sym,
  input  logic [LEN_W-1:0]  req1_start,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              rvld0,
  output logic              rvld1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef RG_RD_ARB_RANGE_CHK_EN
  output logic              err,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q;
  logic                owner_q;
  logic                rr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    iss_cnt_q;
  logic [LEN_W-1:0]    ret_cnt_q;
  logic [LEN_W-1:0]    ret_cnt_d;
  logic [MEM_LAT-1:0]  pipe_q;
  logic                gnt0_q, gnt1_q, done0_q, done1_q, rvld0_q, rvld1_q;
  logic                mem_rd_en_q, busy_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                cap_c;
  logic                all_ret_c;
  logic                sel_c;
  logic [1:0]          sel_sym_c;
  logic [LEN_W-1:0]    sel_start_c;
  logic [LEN_W-1:0]    sel_len_c;
  logic [ADDR_W-1:0]   base_c;
  logic                reject_c;

  // Winner selection, burst base address and return accounting
  always_comb begin
    cap_c       = pipe_q[MEM_LAT-1];
    ret_cnt_d   = ret_cnt_q + LEN_W'(cap_c);
    all_ret_c   = (ret_cnt_d == len_q);
    sel_c       = (req0 && req1) ? rr_q : req1;
    sel_sym_c   = sel_c ? req1_sym   : req0_sym;
    sel_start_c = sel_c ? req1_start : req0_start;
    sel_len_c   = sel_c ? req1_len   : req0_len;
    base_c      = ADDR_W'(sel_sym_c) * ADDR_W'(SC_PER_SYM) + ADDR_W'(sel_start_c);
  end

`ifdef RG_RD_ARB_RANGE_CHK_EN
  logic err_q;
  assign reject_c = (32'(sel_start_c) + 32'(sel_len_c)) > 32'(SC_PER_SYM);
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && (req0 || req1) && reject_c) begin
      err_q <= 1'b1;
    end
  end
`else
  assign reject_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      len_q       <= '0;
      iss_cnt_q   <= '0;
      ret_cnt_q   <= '0;
      pipe_q      <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rvld0_q     <= 1'b0;
      rvld1_q     <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      // Read-latency tracker: one bit per outstanding read, oldest at the top
      pipe_q    <= (pipe_q << 1) | MEM_LAT'(mem_rd_en_q);
      rvld0_q   <= cap_c && !owner_q;
      rvld1_q   <= cap_c && owner_q;
      ret_cnt_q <= ret_cnt_d;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      if (cap_c) begin
        rdata_q <= mem_rdata;
      end

      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            owner_q   <= sel_c;
            gnt0_q    <= !sel_c;
            gnt1_q    <= sel_c;
            busy_q    <= 1'b1;
            ret_cnt_q <= '0;
            if (req0 && req1) begin
              rr_q <= !sel_c;
            end
            if (reject_c || sel_len_c == '0) begin
              len_q   <= '0;
              state_q <= DRAIN;
            end else begin
              len_q       <= sel_len_c;
              iss_cnt_q   <= LEN_W'(1);
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= base_c;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (iss_cnt_q == len_q) begin
            mem_rd_en_q <= 1'b0;
            state_q     <= DRAIN;
          end else begin
            iss_cnt_q  <= iss_cnt_q + LEN_W'(1);
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Done is raised on the same edge that registers the final data word
          if (all_ret_c) begin
            done0_q <= !owner_q;
            done1_q <= owner_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rvld0     = rvld0_q;
  assign rvld1     = rvld1_q;
  assign rdata     = rdata_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rg_rd_arb.sv
// tb_rg_rd_arb: randomized self-checking bench for rg_rd_arb against a transaction-level model
// (round-robin pending set, address/data lists computed from sym*SC+start+k and a RAM content function).
module tb_rg_rd_arb;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned SC     = 240;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned LAT    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1;
  logic [1:0]        req0_sym, req1_sym;
  logic [LEN_W-1:0]  req0_start, req0_len, req1_start, req1_len;
  logic              gnt0, gnt1, done0, done1, rvld0, rvld1, mem_rd_en, busy;
  logic [DATA_W-1:0] rdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
`ifdef RG_RD_ARB_RANGE_CHK_EN
  logic              err;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int m_rr   = 0;

  always #5 clk = ~clk;

  rg_rd_arb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SC_PER_SYM(SC), .LEN_W(LEN_W), .MEM_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req0_sym(req0_sym), .req0_start(req0_start), .req0_len(req0_len),
    .req1(req1), .req1_sym(req1_sym), .req1_start(req1_start), .req1_len(req1_len),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rvld0(rvld0), .rvld1(rvld1), .rdata(rdata),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
`ifdef RG_RD_ARB_RANGE_CHK_EN
    .err(err),
`endif
    .busy(busy)
  );

  function automatic logic [DATA_W-1:0] mem_fn(input int a);
    return DATA_W'((32'(a) * 32'h9E37_79B1) ^ 32'h00C0_FFEE);
  endfunction

  // RAM model: data for the address presented in cycle c is visible in cycle c+LAT
  logic [ADDR_W-1:0] sh_addr [LAT];
  always @(posedge clk) begin
    sh_addr[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) sh_addr[i] <= sh_addr[i-1];
  end
  assign mem_rdata = mem_fn(int'(sh_addr[LAT-1]));

  int q_addr[$], q_acyc[$], q_rown[$], q_rcyc[$], q_down[$], q_dcyc[$], q_gown[$], q_gcyc[$], q_fcyc[$];
  logic [DATA_W-1:0] q_data[$];
  bit both_gnt, both_rv, bad_rv;
  logic pg0 = 1'b0, pg1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_rd_en) begin q_addr.push_back(int'(mem_addr)); q_acyc.push_back(cyc); end
    if (rvld0 || rvld1) begin
      q_data.push_back(rdata); q_rown.push_back(rvld1 ? 1 : 0); q_rcyc.push_back(cyc);
    end
    if (done0) begin q_down.push_back(0); q_dcyc.push_back(cyc); end
    if (done1) begin q_down.push_back(1); q_dcyc.push_back(cyc); end
    if (gnt0 && !pg0) begin q_gown.push_back(0); q_gcyc.push_back(cyc); end
    if (gnt1 && !pg1) begin q_gown.push_back(1); q_gcyc.push_back(cyc); end
    if ((!gnt0 && pg0) || (!gnt1 && pg1)) q_fcyc.push_back(cyc);
    if (gnt0 && gnt1) both_gnt = 1'b1;
    if (rvld0 && rvld1) both_rv = 1'b1;
    if ((rvld0 && !gnt0) || (rvld1 && !gnt1)) bad_rv = 1'b1;
    pg0 = gnt0;
    pg1 = gnt1;
  end

  task automatic clear_logs();
    q_addr.delete(); q_acyc.delete(); q_data.delete(); q_rown.delete(); q_rcyc.delete();
    q_down.delete(); q_dcyc.delete(); q_gown.delete(); q_gcyc.delete(); q_fcyc.delete();
    both_gnt = 1'b0; both_rv = 1'b0; bad_rv = 1'b0;
  endtask

  // Mismatch count of one burst's addresses/data against the model, starting at log indices a0/r0
  function automatic int burst_errs(input int sym, input int st, input int ln, input int own,
                                    input int a0, input int r0);
    int e = 0;
    int ea;
    if (q_addr.size() != a0 + ln) e++;
    if (q_data.size() != r0 + ln) e++;
    for (int k = 0; k < ln; k++) begin
      ea = (sym * int'(SC) + st + k) % (1 << ADDR_W);
      if (a0 + k >= q_addr.size() || q_addr[a0+k] != ea) e++;
      if (r0 + k >= q_data.size() || q_data[r0+k] !== mem_fn(ea) || q_rown[r0+k] != own) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    req0 = 1'b0; req0_sym = '0; req0_start = '0; req0_len = '0;
    req1 = 1'b0; req1_sym = '0; req1_start = '0; req1_len = '0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({gnt0, gnt1, done0, done1, rvld0, rvld1, mem_rd_en, busy} !== 8'h00)
      $display("FAIL reset_ctrl: got %b expected 00000000", {gnt0, gnt1, done0, done1, rvld0, rvld1, mem_rd_en, busy});
    else n_pass++;
    n_chk++;
    if (mem_addr !== '0 || rdata !== '0)
      $display("FAIL reset_data: got addr=%0h rdata=%0h expected 0/0", mem_addr, rdata);
    else n_pass++;
`ifdef RG_RD_ARB_RANGE_CHK_EN
    n_chk++;
    if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({gnt0, gnt1, mem_rd_en, busy} !== 4'h0)
      $display("FAIL idle_no_req: got %b expected 0000", {gnt0, gnt1, mem_rd_en, busy});
    else n_pass++;
  endtask

  task automatic test_single_burst();
    int rc, e;
    bit to;
    clear_logs();
    @(negedge clk); #1;
    req0_sym = 2'd1; req0_start = LEN_W'(10); req0_len = LEN_W'(4); req0 = 1'b1;
    rc = cyc;
    to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (q_down.size() > 0) begin to = 1'b0; break; end
    end
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (to) $display("FAIL single_timeout: got no done0 expected done0 within 100 cycles"); else n_pass++;
    e = 0;
    if (q_addr.size() != 4) e++;
    for (int k = 0; k < 4; k++)
      if (k >= q_addr.size() || q_addr[k] != 250 + k || q_acyc[k] != q_acyc[0] + k) e++;
    n_chk++;
    if (e != 0) $display("FAIL single_addr_seq: got %0d bad entries expected 0 (250..253 consecutive)", e);
    else n_pass++;
    e = burst_errs(1, 10, 4, 0, 0, 0);
    n_chk++;
    if (e != 0) $display("FAIL single_data: got %0d errors expected 0", e); else n_pass++;
    n_chk++;
    if (q_rcyc.size() < 1 || q_acyc.size() < 1 || q_rcyc[0] != q_acyc[0] + 3)
      $display("FAIL single_rvld_lat: got %0d cycles expected 3",
               (q_rcyc.size() > 0 && q_acyc.size() > 0) ? q_rcyc[0] - q_acyc[0] : -1);
    else n_pass++;
    n_chk++;
    if (q_down.size() != 1 || q_rcyc.size() != 4 || q_down[0] != 0 || q_dcyc[0] != q_rcyc[3])
      $display("FAIL single_done_align: got %0d done pulses expected 1 with 4th rvld0", q_down.size());
    else n_pass++;
    n_chk++;
    if (q_gown.size() != 1 || q_gown[0] != 0 || q_gcyc[0] != rc + 1 || q_acyc.size() < 1 || q_acyc[0] != q_gcyc[0])
      $display("FAIL single_grant: got %0d grants expected one gnt0 the cycle after request", q_gown.size());
    else n_pass++;
    n_chk++;
    if (q_fcyc.size() != 1 || q_dcyc.size() != 1 || q_fcyc[0] != q_dcyc[0] + 1)
      $display("FAIL single_gnt_drop: got %0d expected %0d",
               q_fcyc.size() > 0 ? q_fcyc[0] : -1, q_dcyc.size() > 0 ? q_dcyc[0] + 1 : -1);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int sym[2], st[2], ln[2];
    int w, a0, r0, g0, d0, e, prev_d, gc;
    bit to;
    clear_logs();
    for (int i = 0; i < 2; i++) begin
      sym[i] = $urandom_range(0, 3);
      ln[i]  = $urandom_range(1, 12);
      st[i]  = $urandom_range(0, SC - ln[i]);
    end
    @(negedge clk); #1;
    req0_sym = 2'(sym[0]); req0_start = LEN_W'(st[0]); req0_len = LEN_W'(ln[0]);
    req1_sym = 2'(sym[1]); req1_start = LEN_W'(st[1]); req1_len = LEN_W'(ln[1]);
    req0 = 1'b1; req1 = 1'b1;
    prev_d = -1;
    for (int b = 0; b < 4; b++) begin
      w = m_rr; m_rr = 1 - w;
      a0 = q_addr.size(); r0 = q_data.size(); g0 = q_gown.size(); d0 = q_down.size();
      to = 1'b1;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk); #1;
        if (q_down.size() > d0) begin to = 1'b0; break; end
      end
      if (b == 3 || to) begin req0 = 1'b0; req1 = 1'b0; end
      n_chk++;
      if (to || q_gown.size() <= g0 || q_gown[g0] != w)
        $display("FAIL rr_order: burst %0d got owner %0d expected %0d", b, q_gown.size() > g0 ? q_gown[g0] : -1, w);
      else n_pass++;
      if (to) break;
      e = burst_errs(sym[w], st[w], ln[w], w, a0, r0);
      gc = q_gcyc[g0];
      if (prev_d >= 0 && gc != prev_d + 2) e++;
      prev_d = q_dcyc[d0];
      n_chk++;
      if (e != 0) $display("FAIL rr_burst: burst %0d got %0d errors expected 0", b, e); else n_pass++;
    end
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({both_gnt, both_rv, bad_rv} !== 3'b000)
      $display("FAIL rr_exclusive: got %b expected 000", {both_gnt, both_rv, bad_rv});
    else n_pass++;
  endtask

  task automatic test_len0();
    int d0;
    bit to;
    clear_logs();
    @(negedge clk); #1;
    req1_sym = 2'd2; req1_start = LEN_W'(17); req1_len = '0; req1 = 1'b1;
    to = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (q_down.size() > 0) begin to = 1'b0; break; end
    end
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (to || q_down.size() != 1 || q_down[0] != 1 || q_gown.size() != 1 || q_dcyc[0] != q_gcyc[0] + 1)
      $display("FAIL len0_done: got %0d done pulses expected done1 one cycle after gnt1", q_down.size());
    else n_pass++;
    d0 = q_addr.size() + q_data.size();
    n_chk++;
    if (d0 != 0) $display("FAIL len0_no_reads: got %0d reads/rvld expected 0", d0); else n_pass++;
  endtask

  task automatic test_long_burst();
    int e;
    bit to, moved;
    clear_logs();
    @(negedge clk); #1;
    req0_sym = 2'd3; req0_start = '0; req0_len = LEN_W'(240); req0 = 1'b1;
    to = 1'b1; moved = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      if (!moved && q_addr.size() >= 50) begin
        req0_sym = 2'd0; req0_start = LEN_W'(7); req0_len = LEN_W'(3); moved = 1'b1;
      end
      if (q_down.size() > 0) begin to = 1'b0; break; end
    end
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (to || q_addr.size() != 240 || q_addr[239] != 959)
      $display("FAIL long_last_addr: got %0d reads last=%0d expected 240 reads last=959",
               q_addr.size(), q_addr.size() > 0 ? q_addr[q_addr.size()-1] : -1);
    else n_pass++;
    e = burst_errs(3, 0, 240, 0, 0, 0);
    n_chk++;
    if (e != 0 || q_data.size() != 240)
      $display("FAIL long_data: got %0d errors %0d rvld0 expected 0 errors 240 rvld0", e, q_data.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int d0, rsz;
    bit to;
    clear_logs();
    @(negedge clk); #1;
    req0_sym = 2'd0; req0_start = LEN_W'(5); req0_len = LEN_W'(20); req0 = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (q_data.size() >= 5) break;
    end
    n_chk++;
    if (busy !== 1'b1 || gnt0 !== 1'b1) $display("FAIL mid_busy: got busy=%b gnt0=%b expected 1/1", busy, gnt0);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({gnt0, gnt1, done0, done1, rvld0, rvld1, mem_rd_en, busy} !== 8'h00 || rdata !== '0 || mem_addr !== '0)
      $display("FAIL mid_reset_outputs: got %b expected 00000000", {gnt0, gnt1, done0, done1, rvld0, rvld1, mem_rd_en, busy});
    else n_pass++;
    req0 = 1'b0;
    d0 = q_down.size(); rsz = q_data.size();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    m_rr = 0;
    repeat (6) @(negedge clk);
    #1;
    n_chk++;
    if (q_down.size() != d0 || q_data.size() != rsz)
      $display("FAIL mid_abort: got %0d done %0d rvld expected %0d done %0d rvld", q_down.size(), q_data.size(), d0, rsz);
    else n_pass++;
    clear_logs();
    req1_sym = 2'd2; req1_start = LEN_W'(100); req1_len = LEN_W'(3); req1 = 1'b1;
    to = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (q_down.size() > 0) begin to = 1'b0; break; end
    end
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (to || q_gown.size() < 1 || q_gown[0] != 1 || burst_errs(2, 100, 3, 1, 0, 0) != 0)
      $display("FAIL post_reset_req1: got first owner %0d expected 1 with clean burst", q_gown.size() > 0 ? q_gown[0] : -1);
    else n_pass++;
  endtask

  task automatic test_random(input int rounds);
    int sym[2], st[2], ln[2];
    int pat, rc, prev_d, a0, r0, g0, d0, w, o, e, gc, dc;
    bit pend[2];
    bit to;
    clear_logs();
    for (int r = 0; r < rounds; r++) begin
      pat = $urandom_range(1, 3);
      for (int i = 0; i < 2; i++) begin
        sym[i]  = $urandom_range(0, 3);
        ln[i]   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 24);
        st[i]   = $urandom_range(0, SC - ln[i]);
        pend[i] = pat[i];
      end
      @(negedge clk); #1;
      req0_sym = 2'(sym[0]); req0_start = LEN_W'(st[0]); req0_len = LEN_W'(ln[0]);
      req1_sym = 2'(sym[1]); req1_start = LEN_W'(st[1]); req1_len = LEN_W'(ln[1]);
      req0 = pend[0]; req1 = pend[1];
      rc = cyc; prev_d = -1;
      while (pend[0] || pend[1]) begin
        if (pend[0] && pend[1]) begin w = m_rr; m_rr = 1 - w; end
        else w = pend[1] ? 1 : 0;
        a0 = q_addr.size(); r0 = q_data.size(); g0 = q_gown.size(); d0 = q_down.size();
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
          @(negedge clk); #1;
          if (q_down.size() > d0) begin to = 1'b0; break; end
        end
        o = to ? w : q_down[d0];
        if (o == 0) req0 = 1'b0; else req1 = 1'b0;
        pend[o] = 1'b0;
        n_chk++;
        if (to || q_gown.size() <= g0 || q_gown[g0] != w || o != w)
          $display("FAIL rand_owner: round %0d got %0d expected %0d", r, q_gown.size() > g0 ? q_gown[g0] : -1, w);
        else n_pass++;
        if (to) begin req0 = 1'b0; req1 = 1'b0; return; end
        e = burst_errs(sym[w], st[w], ln[w], w, a0, r0);
        n_chk++;
        if (e != 0) $display("FAIL rand_burst: round %0d got %0d errors expected 0", r, e); else n_pass++;
        gc = q_gcyc[g0];
        dc = q_dcyc[d0];
        e = 0;
        if (gc != ((prev_d < 0) ? rc + 1 : prev_d + 2)) e++;
        if (ln[w] == 0) begin
          if (dc != gc + 1) e++;
        end else begin
          if (q_acyc[a0] != gc) e++;
          if (q_rcyc[r0] != q_acyc[a0] + int'(LAT) + 1) e++;
          if (dc != q_rcyc[r0 + ln[w] - 1]) e++;
        end
        n_chk++;
        if (e != 0) $display("FAIL rand_timing: round %0d got %0d errors expected 0", r, e); else n_pass++;
        prev_d = dc;
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    #1;
    n_chk++;
    if ({both_gnt, both_rv, bad_rv} !== 3'b000)
      $display("FAIL rand_exclusive: got %b expected 000", {both_gnt, both_rv, bad_rv});
    else n_pass++;
  endtask

`ifdef RG_RD_ARB_RANGE_CHK_EN
  task automatic test_range_chk();
    bit to;
    clear_logs();
    @(negedge clk); #1;
    req0_sym = 2'd0; req0_start = LEN_W'(230); req0_len = LEN_W'(20); req0 = 1'b1;
    to = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (q_down.size() > 0) begin to = 1'b0; break; end
    end
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_chk++;
    if (to || q_addr.size() != 0 || q_down[0] != 0 || q_dcyc[0] != q_gcyc[0] + 1)
      $display("FAIL range_reject: got %0d reads expected 0 reads and done0 after grant", q_addr.size());
    else n_pass++;
    n_chk++;
    if (err !== 1'b1) $display("FAIL range_err_sticky: got %b expected 1", err); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++;
    if (err !== 1'b0) $display("FAIL range_err_reset: got %b expected 0", err); else n_pass++;
    @(negedge clk); #1;
    rst = 1'b1;
    m_rr = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_len0();
    test_long_burst();
    test_reset_mid_burst();
    test_random(30);
`ifdef RG_RD_ARB_RANGE_CHK_EN
    test_range_chk();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rg_rd_arb.md
Name: rg_rd_arb

Overview:
- Arbiter and read sequencer for the post-FFT resource-grid RAM. The RAM holds 4 SSB symbols × SC_PER_SYM subcarriers.
- Shares the single RAM read port between two requesters:
  - requester 0: DMRS / channel-estimation extractor.
  - requester 1: PBCH equalizer data extractor.
- Per granted request it issues a burst of consecutive reads, routes the returned data to the owner, then signals completion.
- Sits between the post-FFT buffer and the channel-estimation and equalization blocks.

Parameters:
- DATA_W, 32, RAM word width (packed complex RE).
- ADDR_W, 10, RAM address width; must hold 4*SC_PER_SYM-1.
- SC_PER_SYM, 240, subcarriers per stored symbol.
- LEN_W, 8, width of start and length fields.
- MEM_LAT, 2, RAM read latency in cycles from mem_rd_en to valid mem_rdata, ≥1.

Ports:
- clk input 1 system clock.
- rst input 1 asynchronous active-low reset.
- req0 input 1 requester 0 request, level, held until done0.
- req0_sym input 2 requester 0 symbol index 0..3.
- req0_start input LEN_W requester 0 first subcarrier.
- req0_len input LEN_W requester 0 RE count.
- req1 input 1 requester 1 request.
- req1_sym input 2 requester 1 symbol index 0..3.
- req1_start input LEN_W requester 1 first subcarrier.
- req1_len input LEN_W requester 1 RE count.
- gnt0 output 1 requester 0 owns the RAM port, level.
- gnt1 output 1 requester 1 owns the RAM port, level.
- done0 output 1 one-cycle pulse: last data of requester 0 burst delivered.
- done1 output 1 one-cycle pulse: last data of requester 1 burst delivered.
- rvld0 output 1 rdata valid for requester 0.
- rvld1 output 1 rdata valid for requester 1.
- rdata output DATA_W registered read data, shared by both requesters.
- mem_rd_en output 1 RAM read enable.
- mem_addr output ADDR_W RAM read address.
- mem_rdata input DATA_W RAM read data.
- busy output 1 arbiter not IDLE.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; counters cleared; round-robin pointer set to requester 0. Reset mid-burst aborts with no done pulse; in-flight RAM data is discarded.
- FSM states:
  - IDLE → ISSUE when req0 or req1 is high.
  - ISSUE → DRAIN after the last read is issued.
  - DRAIN → DONE when the issued-read count equals the returned count.
  - DONE → IDLE after 1 cycle.
- Arbitration (IDLE only):
  - Single request: grant it.
  - Both requests: grant the requester that the round-robin pointer favours, then point the pointer at the other requester.
- Grant timing: gnt asserts the cycle after IDLE samples the request and stays high through DONE. sym, start and len are latched at grant; later changes are ignored.
- ISSUE addressing: mem_rd_en=1 each cycle; mem_addr = sym*SC_PER_SYM + start + k, with k = 0..len-1, computed at ADDR_W width with no wrap check.
- Data return: rvld_owner asserts for exactly len cycles. rdata is mem_rdata registered, so rvld lags mem_rd_en by MEM_LAT+1 cycles.
- Completion: done_owner pulses in the same cycle as the last rvld_owner, and gnt drops in the following cycle.
- len=0: ISSUE is skipped and no reads occur; done pulses in the cycle after grant.
- Request deasserted mid-burst: ignored; the burst completes.
- Request still high in the cycle after done: treated as a new request and re-arbitrated in IDLE.
- Back-to-back requests: a minimum of 1 IDLE cycle separates bursts.
- Only one gnt and one rvld are ever high at a time.

Optional Feature:
- Macro: RG_RD_ARB_RANGE_CHK_EN.
- Defined:
  - At grant, if start+len > SC_PER_SYM, the request is rejected.
  - No reads are issued.
  - done_owner pulses in the cycle after grant.
  - A sticky output err (1 bit) sets and clears only on reset.
- Undefined: no check is made, the err port is absent, and addresses are used as computed.

Test Plan:
- req0 with sym=1, start=10, len=4; MEM_LAT=2 → mem_addr 250,251,252,253 on 4 consecutive cycles; rvld0 for 4 cycles starting 3 cycles after the first mem_rd_en; done0 with the 4th rvld0; gnt1 never high.
- req0 and req1 asserted in the same cycle, with both held after their first done → grants go 0,1,0,1 alternately; never both gnt high.
- req1 with len=0 → no mem_rd_en; done1 1 cycle after gnt1.
- req0 with sym=3, start=0, len=240 → last address 959; 240 rvld0 pulses; req0_sym changed mid-burst has no effect.
- rst driven low in the middle of a len=20 burst → all outputs 0 immediately; no done0; after release a new req1 is granted first.
- With RG_RD_ARB_RANGE_CHK_EN defined, req0 with start=230, len=20 → no reads; done0 pulse; err=1 held until reset.
